// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: one read cycle then one write cycle per word.
// Optional MEM_COPY_FILL_EN adds a fill mode that writes a constant without reading.
module mem_copy_dma #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
`ifdef MEM_COPY_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   words_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   words_done_q;
    logic [DATA_W-1:0] buf_q;
    logic [ADDR_W:0]   words_inc;
    logic              fill_q;
    logic [DATA_W-1:0] fill_val_q;

    assign words_inc = words_done_q + ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            buf_q        <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q        <= src_addr;
                        dst_q        <= dst_addr;
                        len_q        <= len;
                        words_done_q <= '0;
                    end
                end
                READ:    buf_q        <= mem_rdata;
                WRITE:   words_done_q <= words_inc;
                default: ;
            endcase
        end
    end

`ifdef MEM_COPY_FILL_EN
    // Fill settings are captured with the rest of the transfer parameters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else if (state == IDLE && start) begin
            fill_q     <= fill;
            fill_val_q <= fill_value;
        end
    end
`else
    assign fill_q     = 1'b0;
    assign fill_val_q = '0;
`endif

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wd    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)
                        state_nxt = FINISH;
`ifdef MEM_COPY_FILL_EN
                    else if (fill)
                        state_nxt = WRITE;
`endif
                    else
                        state_nxt = READ;
                end
            end
            READ: begin
                mem_rd    = 1'b1;
                mem_addr  = src_q + words_done_q[ADDR_W-1:0];
                state_nxt = WRITE;
            end
            WRITE: begin
                mem_wr   = 1'b1;
                mem_addr = dst_q + words_done_q[ADDR_W-1:0];
                mem_wd   = fill_q ? fill_val_q : buf_q;
                if (words_inc == len_q)
                    state_nxt = FINISH;
                else if (fill_q)
                    state_nxt = WRITE;
                else
                    state_nxt = READ;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);
    assign words_done = words_done_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a behavioural data memory.
// Fill-mode vectors are included when MEM_COPY_FILL_EN is defined.
module tb_mem_copy_dma;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [ADDR_W:0]   len = '0;
`ifdef MEM_COPY_FILL_EN
    logic              fill = 1'b0;
    logic [DATA_W-1:0] fill_value = '0;
`endif
    logic              busy, done, mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd, mem_rdata;
    logic [ADDR_W:0]   words_done;

    logic [DATA_W-1:0] mem [4096];

    int checks = 0;
    int failures = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, both_cnt = 0;
    logic [ADDR_W-1:0] rd_log [$];
    int cyc;

    mem_copy_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
`ifdef MEM_COPY_FILL_EN
        .fill(fill), .fill_value(fill_value),
`endif
        .busy(busy), .done(done), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rdata(mem_rdata),
        .words_done(words_done)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_rd ? mem[mem_addr] : '0;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wd;
        if (mem_rd) begin
            rd_cnt <= rd_cnt + 1;
            rd_log.push_back(mem_addr);
        end
        if (mem_wr) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then count cycles until done (bounded).
    task automatic run(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                       input logic [ADDR_W:0] n, output int cycles);
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        cycles = 0;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic clear_mon();
        @(negedge clk);
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; both_cnt = 0;
        rd_log.delete();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'hFFFF;
        mem[0] = 16'h0002; mem[1] = 16'h0008; mem[2] = 16'h0040; mem[3] = 16'h0011;
        mem[4094] = 16'h1111; mem[4095] = 16'h2222;

        // Reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_rd", {31'd0, mem_rd}, 0);
        chk("rst_wr", {31'd0, mem_wr}, 0);
        chk("rst_addr", {20'd0, mem_addr}, 0);
        chk("rst_wd", {16'd0, mem_wd}, 0);
        chk("rst_wdone", {19'd0, words_done}, 0);
        @(negedge clk); rst_n = 1'b1;

        // Basic 4-word copy
        clear_mon();
        run(12'd0, 12'd100, 13'd4, cyc);
        chk("copy_cycles", cyc, 9);
        chk("copy_wdone", {19'd0, words_done}, 4);
        @(posedge clk); #1;
        chk("copy_m100", {16'd0, mem[100]}, 32'h0002);
        chk("copy_m101", {16'd0, mem[101]}, 32'h0008);
        chk("copy_m102", {16'd0, mem[102]}, 32'h0040);
        chk("copy_m103", {16'd0, mem[103]}, 32'h0011);
        chk("copy_m104", {16'd0, mem[104]}, 32'hFFFF);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_wdone_hold", {19'd0, words_done}, 4);
        chk("copy_both", both_cnt, 0);
        chk("copy_done_cnt", done_cnt, 1);

        // Zero-length transfer
        clear_mon();
        run(12'd0, 12'd500, 13'd0, cyc);
        chk("len0_cycles", cyc, 1);
        chk("len0_wdone", {19'd0, words_done}, 0);
        chk("len0_busy_fin", {31'd0, busy}, 1);
        @(posedge clk); #1;
        chk("len0_rd", rd_cnt, 0);
        chk("len0_wr", wr_cnt, 0);

        // Address wrap on the source side
        clear_mon();
        run(12'd4094, 12'd10, 13'd3, cyc);
        @(posedge clk); #1;
        chk("wrap_cycles", cyc, 7);
        chk("wrap_nreads", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            chk("wrap_rd0", {20'd0, rd_log[0]}, 4094);
            chk("wrap_rd1", {20'd0, rd_log[1]}, 4095);
            chk("wrap_rd2", {20'd0, rd_log[2]}, 0);
        end
        chk("wrap_m10", {16'd0, mem[10]}, 32'h1111);
        chk("wrap_m11", {16'd0, mem[11]}, 32'h2222);
        chk("wrap_m12", {16'd0, mem[12]}, 32'h0002);

        // Second start mid-transfer is ignored
        clear_mon();
        src_addr = 12'd0; dst_addr = 12'd300; len = 13'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            if (cyc == 3) begin
                src_addr = 12'd50; dst_addr = 12'd900; len = 13'd2; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("mid_cycles", cyc, 9);
        chk("mid_wdone", {19'd0, words_done}, 4);
        @(posedge clk); #1;
        chk("mid_m300", {16'd0, mem[300]}, 32'h0002);
        chk("mid_m303", {16'd0, mem[303]}, 32'h0011);
        chk("mid_m900", {16'd0, mem[900]}, 32'hFFFF);
        chk("mid_wr", wr_cnt, 4);

        // Reset during the third WRITE
        clear_mon();
        src_addr = 12'd0; dst_addr = 12'd200; len = 13'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 6; k++) begin
            @(posedge clk); #1;
        end
        chk("rstx_in_write", {31'd0, mem_wr}, 1);
        rst_n = 1'b0;
        #1;
        chk("rstx_busy", {31'd0, busy}, 0);
        chk("rstx_wr", {31'd0, mem_wr}, 0);
        chk("rstx_addr", {20'd0, mem_addr}, 0);
        chk("rstx_wd", {16'd0, mem_wd}, 0);
        chk("rstx_wdone", {19'd0, words_done}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstx_m200", {16'd0, mem[200]}, 32'h0002);
        chk("rstx_m201", {16'd0, mem[201]}, 32'h0008);
        chk("rstx_m202", {16'd0, mem[202]}, 32'hFFFF);
        chk("rstx_done", done_cnt, 0);

        // Start accepted on the first edge after reset release
        @(negedge clk); rst_n = 1'b1;
        run(12'd3, 12'd700, 13'd1, cyc);
        chk("post_rst_cycles", cyc, 3);
        @(posedge clk); #1;
        chk("post_rst_m700", {16'd0, mem[700]}, 32'h0011);

`ifdef MEM_COPY_FILL_EN
        clear_mon();
        fill = 1'b1; fill_value = 16'hABCD;
        run(12'd0, 12'd20, 13'd5, cyc);
        fill = 1'b0;
        chk("fill_cycles", cyc, 6);
        @(posedge clk); #1;
        chk("fill_rd", rd_cnt, 0);
        for (int i = 20; i < 25; i++) chk("fill_word", {16'd0, mem[i]}, 32'hABCD);
        chk("fill_m25", {16'd0, mem[25]}, 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 SHALL have parameters: ADDR_W, default 12, memory address width; DATA_W, default 16, memory word width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: single-cycle request to begin a copy.
REQ-005 SHALL have port src_addr, input, ADDR_W bits: first source word address, sampled on an accepted start.
REQ-006 SHALL have port dst_addr, input, ADDR_W bits: first destination word address, sampled on an accepted start.
REQ-007 SHALL have port len, input, ADDR_W+1 bits: word count, sampled on an accepted start; 0 is legal.
REQ-008 SHALL have port busy, output, 1 bit: high while a transfer is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a transfer completes.
REQ-010 SHALL have port mem_rd, output, 1 bit: data-memory read enable.
REQ-011 SHALL have port mem_wr, output, 1 bit: data-memory write enable; memory writes on the rising clk edge.
REQ-012 SHALL have port mem_addr, output, ADDR_W bits: data-memory access address.
REQ-013 SHALL have port mem_wd, output, DATA_W bits: data-memory write data.
REQ-014 SHALL have port mem_rdata, input, DATA_W bits: combinational read data, valid in the same cycle mem_rd is high.
REQ-015 SHALL have port words_done, output, ADDR_W+1 bits: count of words written in the current or last transfer.

Function
REQ-016 SHALL implement states IDLE, READ, WRITE, FINISH.
REQ-017 In IDLE, start=1 SHALL capture src_addr, dst_addr and len, clear words_done, and go to READ if len!=0, else to FINISH.
REQ-018 In READ: mem_rd=1, mem_wr=0, mem_addr=src+words_done; the clk edge SHALL latch mem_rdata into a data buffer, then go to WRITE.
REQ-019 In WRITE: mem_wr=1, mem_rd=0, mem_addr=dst+words_done, mem_wd=buffer; the clk edge SHALL increment words_done, then go to FINISH if the incremented count equals len, else to READ.
REQ-020 In FINISH, done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-021 Each word SHALL take exactly 2 cycles; done SHALL assert 2*len+1 cycles after the start cycle (1 cycle for len=0).
REQ-022 Address sums SHALL wrap modulo 2^ADDR_W (4095+1 -> 0).
REQ-023 busy SHALL be 1 in READ, WRITE and FINISH, and 0 in IDLE.
REQ-024 start SHALL be ignored when not in IDLE; captured parameters SHALL NOT change mid-transfer.
REQ-025 mem_rd and mem_wr SHALL never both be 1; both SHALL be 0 in IDLE and FINISH.
REQ-026 Overlapping source/destination ranges SHALL copy strictly in ascending word order, with no hazard handling.
REQ-027 words_done SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and set busy=0, done=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wd=0, words_done=0, and the buffer to 0.
REQ-029 Reset during a transfer SHALL abort it with no done pulse; memory already written SHALL remain as written.
REQ-030 After rst_n is released, the block SHALL accept start on the first rising clk edge.

Configuration
REQ-031 Macro MEM_COPY_FILL_EN SHALL, when defined, add inputs fill (1 bit) and fill_value (DATA_W bits), both sampled on an accepted start.
REQ-032 With MEM_COPY_FILL_EN defined and fill=1, the block SHALL skip READ and write fill_value to dst+i in consecutive WRITE cycles, so done asserts len+1 cycles after start.
REQ-033 Without MEM_COPY_FILL_EN, these ports SHALL NOT exist and all transfers SHALL be copies.

Verification
REQ-034 Memory words 0..3 = 0002,0008,0040,0011; start with src=0, dst=100, len=4 -> words 100..103 equal 0002,0008,0040,0011; done 9 cycles after start; words_done=4.
REQ-035 start with len=0 -> done 1 cycle later; mem_rd and mem_wr never high.
REQ-036 src=4094, dst=10, len=3 -> reads 4094, 4095, 0 in that order.
REQ-037 Second start pulse mid-transfer -> ignored; the original transfer completes unchanged.
REQ-038 rst_n low during the third WRITE -> outputs 0 immediately; exactly 2 words written; no done pulse.
REQ-039 With MEM_COPY_FILL_EN: fill=1, fill_value=ABCD, dst=20, len=5 -> words 20..24 equal ABCD; mem_rd never high; done 6 cycles after start.
